// File: rtl/mem_loader.sv
// Runtime program loader: byte stream -> big-endian 16-bit words -> memory.
// Optional trailing XOR checksum when LOADER_CHECKSUM_EN is defined.
module mem_loader #(
    parameter int WORD_SIZE   = 16,
    parameter int MEMORY_SIZE = 50,
    parameter int BASE_ADDR   = 0,
    parameter int IO_BASE     = 47
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 mem_write,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_DONE    = 4'd6;
    localparam logic [3:0] S_ERROR   = 4'd7;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CHECK   = 4'd8;
    localparam logic [3:0] S_FIN     = S_CHECK;
`else
    localparam logic [3:0] S_FIN     = S_DONE;
`endif

    // Never let a download reach the I/O words or run off the array.
    localparam int         LIMIT_I = (IO_BASE < MEMORY_SIZE) ? IO_BASE : MEMORY_SIZE;
    localparam logic [16:0] LIMIT  = 17'(LIMIT_I);
    localparam logic [16:0] BASE17 = 17'(BASE_ADDR);

    logic [3:0]           state;
    logic [3:0]           nxt;
    logic                 ready_nxt;
    logic                 accept;
    logic [15:0]          len;
    logic [15:0]          n_new;
    logic [16:0]          end_addr;
    logic [7:0]           hi;
    logic [WORD_SIZE-1:0] idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign accept   = byte_valid & byte_ready;
    assign n_new    = {len[15:8], byte_in};
    assign end_addr = BASE17 + {1'b0, n_new};

    // Next-state decode of the download FSM.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:    if (start) nxt = S_LEN_HI;
            S_LEN_HI:  if (accept) nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (end_addr > LIMIT)
                        nxt = S_ERROR;
                    else if (n_new == 16'd0)
                        nxt = S_FIN;
                    else
                        nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) nxt = S_DATA_LO;
            S_DATA_LO: if (accept) nxt = S_WRITE;
            S_WRITE: begin
                if (17'(idx) + 17'd1 < {1'b0, len})
                    nxt = S_DATA_HI;
                else
                    nxt = S_FIN;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept)
                    nxt = (byte_in == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE:    nxt = S_IDLE;
            S_ERROR:   nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Byte acceptance is registered from the state being entered.
    always_comb begin
        ready_nxt = (nxt == S_LEN_HI) || (nxt == S_LEN_LO) ||
                    (nxt == S_DATA_HI) || (nxt == S_DATA_LO);
`ifdef LOADER_CHECKSUM_EN
        if (nxt == S_CHECK) ready_nxt = 1'b1;
`endif
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_write  <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= '0;
            hi         <= '0;
            idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= nxt;
            byte_ready <= ready_nxt;
            mem_write  <= (nxt == S_WRITE);
            if (state == S_IDLE && start) begin
                done     <= 1'b0;
                error    <= 1'b0;
                cpu_hold <= 1'b1;
                idx      <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == S_LEN_HI && accept)
                len[15:8] <= byte_in;
            if (state == S_LEN_LO && accept)
                len <= n_new;
            if (state == S_DATA_HI && accept) begin
                hi <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ byte_in;
`endif
            end
            if (state == S_DATA_LO && accept) begin
                mem_addr <= WORD_SIZE'(BASE_ADDR) + idx;
                mem_data <= WORD_SIZE'({hi, byte_in});
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ byte_in;
`endif
            end
            if (state == S_WRITE)
                idx <= idx + 1'b1;
            if (nxt == S_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (nxt == S_ERROR)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes queued by stimulus,
// popped and compared by a monitor on every mem_write pulse.
module tb_mem_loader;

    localparam int IO_BASE = 47;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_write;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] wq[$];
    logic [15:0] model_mem[0:49];
    bit          stall = 1'b0;

    mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_write  (mem_write),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mem_write) begin
                chk("write_below_io", 32'(mem_addr < 16'(IO_BASE)), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(e[31:16]));
                    chk("write_data", 32'(mem_data), 32'(e[15:0]));
                end
                if (mem_addr < 16'd50) model_mem[mem_addr] = mem_data;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t == 100) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || error) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got done=0 error=0 expected a flag");
        end
    endtask

    // Stream wq as one download; bad flips checksum bits.
    task automatic load_words(input logic [7:0] bad);
        logic [7:0]  x = 8'h00;
        logic [15:0] n = 16'(wq.size());
        do_start();
        send(n[15:8]);
        send(n[7:0]);
        for (int i = 0; i < wq.size(); i++) begin
            exp_q.push_back({16'(i), wq[i]});
            x = x ^ wq[i][15:8] ^ wq[i][7:0];
            send(wq[i][15:8]);
            send(wq[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        send(x ^ bad);
`else
        if (bad != 8'h00) x = 8'h00;
`endif
        wait_end();
    endtask

    task automatic check_ok(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        for (int i = 0; i < 50; i++) model_mem[i] = 16'h0000;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;

        // Normal load: 0x1234, 0xABCD, checksum 0x40.
        wq = {16'h1234, 16'hABCD};
        do_start();
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_ready", 32'(byte_ready), 32'd1);
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD);
`ifdef LOADER_CHECKSUM_EN
        send(8'h40);
`endif
        wait_end();
        check_ok("normal");
        @(negedge clk);
        chk("done_sticky", 32'(done), 32'd1);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("mem0", 32'(model_mem[0]), 32'h1234);
        chk("mem1", 32'(model_mem[1]), 32'hABCD);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum 0x41: words land, error raised, CPU stays held.
        load_words(8'h01);
        chk("badcs_error", 32'(error), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("badcs_hold", 32'(cpu_hold), 32'd1);
        chk("badcs_error_sticky", 32'(error), 32'd1);
`endif

        // Length 48 overruns the I/O boundary: no writes at all.
        do_start();
        send(8'h00); send(8'h30);
        wait_end();
        chk("len48_error", 32'(error), 32'd1);
        chk("len48_done", 32'(done), 32'd0);
        chk("len48_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);

        // Length 47 fills 0..46.
        wq.delete();
        for (int i = 0; i < 47; i++) wq.push_back({8'(i), 8'(i) ^ 8'h5A});
        load_words(8'h00);
        check_ok("len47");
        chk("len47_last", 32'(model_mem[46]), 32'h2E74);

        // Empty load.
        wq.delete();
        load_words(8'h00);
        check_ok("empty");

        // Randomly stalled 4-word load.
        stall = 1'b1;
        wq = {16'hDEAD, 16'hBEEF, 16'h0F1E, 16'hC3A5};
        load_words(8'h00);
        check_ok("stall");
        chk("stall_mem3", 32'(model_mem[3]), 32'hC3A5);
        stall = 1'b0;

        // Reset after the second word of a 4-word load.
        do_start();
        send(8'h00); send(8'h04);
        exp_q.push_back({16'd0, 16'h1111});
        exp_q.push_back({16'd1, 16'h2222});
        send(8'h11); send(8'h11);
        send(8'h22); send(8'h22);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_write", 32'(mem_write), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_data", 32'(mem_data), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_flags", 32'({done, error}), 32'd0);
        chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        chk("mid_rst_mem1", 32'(model_mem[1]), 32'h2222);

        // Start pulse in DATA_HI is ignored.
        do_start();
        send(8'h00); send(8'h01);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_ready", 32'(byte_ready), 32'd1);
        chk("ign_hold", 32'(cpu_hold), 32'd1);
        exp_q.push_back({16'd0, 16'hBEEF});
        send(8'hBE); send(8'hEF);
`ifdef LOADER_CHECKSUM_EN
        send(8'h51);
`endif
        wait_end();
        check_ok("ignstart");
        chk("ign_mem0", 32'(model_mem[0]), 32'hBEEF);
        @(negedge clk);
        chk("ign_after_ready", 32'(byte_ready), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
